// File: rtl/uart_pkg.sv
// Shared UART types and constants, reusable by the transmitter and a future receiver.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  // Even parity makes the total count of ones even; odd parity is its inverse.
  function automatic logic parity_of(input logic [DATA_W-1:0] data, input logic even);
    return even ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: loads a divider at frame start and flags the last cycle of each bit.
module uart_baud_counter
  import uart_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  output logic             bit_done
);

  logic [DIV_W-1:0] reload_reg;
  logic [DIV_W-1:0] count_reg;
  logic [DIV_W-1:0] period_m1;

  // A divider of zero is treated as one cycle per bit.
  assign period_m1 = (divider == '0) ? '0 : divider - DIV_W'(1);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      reload_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      reload_reg <= period_m1;
      count_reg  <= period_m1;
    end else if (enable) begin
      if (count_reg == '0) count_reg <= reload_reg;
      else                 count_reg <= count_reg - DIV_W'(1);
    end
  end

  assign bit_done = enable && (count_reg == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              write_i,
  input  logic              two_stop_bits_i,
  input  logic              parity_bit_i,
  input  logic              parity_even_i,
  input  logic [DIV_W-1:0]  clock_divider_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              serial_o,
  output logic              busy_o
);

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        bit_idx_reg;
  logic              parity_en_reg;
  logic              parity_val_reg;
  logic              two_stop_reg;
  logic              serial_reg;
  logic              busy_reg;
  logic              start_frame;
  logic              bit_done;

  assign start_frame = (state_reg == IDLE) && write_i;

  uart_baud_counter u_baud (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load     (start_frame),
    .enable   (state_reg != IDLE),
    .divider  (clock_divider_i),
    .bit_done (bit_done)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_idx_reg    <= '0;
      parity_en_reg  <= 1'b0;
      parity_val_reg <= 1'b0;
      two_stop_reg   <= 1'b0;
      serial_reg     <= 1'b1;
      busy_reg       <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          serial_reg <= 1'b1;
          busy_reg   <= 1'b0;
          if (write_i) begin
            state_reg      <= START;
            shift_reg      <= data_i;
            parity_en_reg  <= parity_bit_i;
            parity_val_reg <= parity_of(data_i, parity_even_i);
            two_stop_reg   <= two_stop_bits_i;
            serial_reg     <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end
        START: if (bit_done) begin
          state_reg   <= DATA;
          bit_idx_reg <= '0;
          serial_reg  <= shift_reg[0];
          shift_reg   <= shift_reg >> 1;
        end
        DATA: if (bit_done) begin
          if (bit_idx_reg == 3'd7) begin
            state_reg  <= parity_en_reg ? PARITY : STOP1;
            serial_reg <= parity_en_reg ? parity_val_reg : 1'b1;
          end else begin
            bit_idx_reg <= bit_idx_reg + 3'd1;
            serial_reg  <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
          end
        end
        PARITY: if (bit_done) begin
          state_reg  <= STOP1;
          serial_reg <= 1'b1;
        end
        STOP1: if (bit_done) begin
          // Line stays high; busy drops as soon as the final stop bit completes.
          state_reg <= two_stop_reg ? STOP2 : IDLE;
          busy_reg  <= two_stop_reg;
        end
        STOP2: if (bit_done) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          serial_reg <= 1'b1;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign serial_o = serial_reg;
  assign busy_o   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle frame model plus literal frame-pattern checks.
module tb_uart_tx;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        write_i = 1'b0;
  logic        two_stop_bits_i = 1'b0;
  logic        parity_bit_i = 1'b0;
  logic        parity_even_i = 1'b0;
  logic [15:0] clock_divider_i = 16'd1;
  logic [7:0]  data_i = 8'h00;
  logic        serial_o;
  logic        busy_o;

  int compared = 0;
  int mismatched = 0;

  uart_tx dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .write_i         (write_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .data_i          (data_i),
    .serial_o        (serial_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Model: a queue of {serial, busy} values, one entry per clock, built from the frame rules.
  logic [1:0] exp_q[$];
  logic       exp_serial = 1'b1;
  logic       exp_busy = 1'b1;
  logic       exp_valid = 1'b0;

  always @(posedge clock_i) begin
    logic       bits[$];
    logic [1:0] e;
    int         n;
    if (reset_i) begin
      exp_q.delete();
      exp_serial = 1'b1;
      exp_busy   = 1'b1;
    end else begin
      if (exp_q.size() == 0 && write_i) begin
        n = (clock_divider_i == 16'd0) ? 1 : int'(clock_divider_i);
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data_i[i]);
        if (parity_bit_i) bits.push_back(parity_even_i ? (^data_i) : ~(^data_i));
        bits.push_back(1'b1);
        if (two_stop_bits_i) bits.push_back(1'b1);
        foreach (bits[b])
          for (int k = 0; k < n; k++) exp_q.push_back({bits[b], 1'b1});
        exp_q.push_back(2'b10);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_serial = e[1];
        exp_busy   = e[0];
      end else begin
        exp_serial = 1'b1;
        exp_busy   = 1'b0;
      end
    end
    exp_valid = 1'b1;
  end

  always @(negedge clock_i) begin
    if (exp_valid) begin
      compared++;
      if (serial_o !== exp_serial || busy_o !== exp_busy) begin
        mismatched++;
        $display("FAIL model t=%0t: serial/busy got %b/%b expected %b/%b",
                 $time, serial_o, busy_o, exp_serial, exp_busy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  // Sends one frame and checks the bit pattern (sampled at each bit start) and busy length.
  task automatic do_frame(input string name, input logic [7:0] d, input logic [15:0] div,
                          input logic par, input logic even, input logic two,
                          input int hold, input logic [11:0] exp_bits, input int exp_len);
    logic [11:0] got;
    logic        rec[0:2047];
    int          n;
    int          cycles;
    n = (div == 16'd0) ? 1 : int'(div);
    data_i = d; clock_divider_i = div; parity_bit_i = par;
    parity_even_i = even; two_stop_bits_i = two; write_i = 1'b1;
    @(negedge clock_i);
    data_i = ~d;
    if (hold <= 1) write_i = 1'b0;
    cycles = 0;
    while (busy_o === 1'b1 && cycles < 2000) begin
      rec[cycles] = serial_o;
      cycles++;
      if (cycles + 1 >= hold) write_i = 1'b0;
      @(negedge clock_i);
    end
    write_i = 1'b0;
    if (cycles >= 2000) begin
      compared++; mismatched++;
      $display("FAIL %s timeout: busy still high after %0d cycles, required low", name, cycles);
    end
    got = '0;
    for (int b = 0; b < exp_len; b++)
      if (b * n < cycles) got[b] = rec[b * n];
    check({name, " bits"}, 32'(got), 32'(exp_bits));
    check({name, " busy_cycles"}, 32'(cycles), 32'(exp_len * n));
  endtask

  initial begin
    repeat (3) @(negedge clock_i);
    check("reset busy", 32'(busy_o), 32'd1);
    check("reset serial", 32'(serial_o), 32'd1);
    reset_i = 1'b0;
    @(negedge clock_i);
    check("post-reset busy", 32'(busy_o), 32'd0);
    check("post-reset serial", 32'(serial_o), 32'd1);

    do_frame("8E2 0x55 div1", 8'h55, 16'd1, 1'b1, 1'b1, 1'b1, 1, 12'hCAA, 12);
    do_frame("8N1 0xA3 div1", 8'hA3, 16'd1, 1'b0, 1'b0, 1'b0, 1, 12'h346, 10);
    do_frame("8O1 0x55 div1", 8'h55, 16'd1, 1'b1, 1'b0, 1'b0, 1, 12'h6AA, 11);
    do_frame("8O1 0x07 div1", 8'h07, 16'd1, 1'b1, 1'b0, 1'b0, 1, 12'h40E, 11);
    do_frame("8N1 0x00 div4", 8'h00, 16'd4, 1'b0, 1'b0, 1'b0, 1, 12'h200, 10);
    do_frame("8N1 0x00 div0", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 1, 12'h200, 10);
    do_frame("8N2 0xC5 div3", 8'hC5, 16'd3, 1'b0, 1'b0, 1'b1, 1, 12'h78A, 11);
    do_frame("held write 0x3C", 8'h3C, 16'd1, 1'b0, 1'b0, 1'b0, 3, 12'h278, 10);
    repeat (3) @(negedge clock_i);
    check("idle after held write", 32'(busy_o), 32'd0);

    // Abort a frame part-way through with reset.
    data_i = 8'h00; clock_divider_i = 16'd2; parity_bit_i = 1'b0;
    two_stop_bits_i = 1'b0; write_i = 1'b1;
    @(negedge clock_i);
    write_i = 1'b0;
    repeat (5) @(negedge clock_i);
    check("mid-frame busy", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clock_i);
    check("abort serial", 32'(serial_o), 32'd1);
    check("abort busy", 32'(busy_o), 32'd1);
    reset_i = 1'b0;
    @(negedge clock_i);
    check("after abort busy", 32'(busy_o), 32'd0);
    do_frame("post-abort 8N1 0xA3", 8'hA3, 16'd2, 1'b0, 1'b0, 1'b0, 1, 12'h346, 10);
    repeat (2) @(negedge clock_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
